// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory combinationally and
// fills the IF/ID register, honouring stall, redirect and HALT.
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [3:0]      HALT_OP  = 4'hF,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stopPipe,
    input  logic              selPC,
    input  logic [PC_W-1:0]   branchTarget,
    output logic [PC_W-1:0]   instAddr,
    input  logic [INST_W-1:0] instData,
    output logic [INST_W-1:0] instD,
    output logic [PC_W-1:0]   pcD,
    output logic              validD,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [PC_W-1:0]     pc, pc_nx;
    logic [INST_W-1:0]   inst_nx;
    logic [PC_W-1:0]     pcd_nx;
    logic                valid_nx;
    logic                is_halt;

    assign instAddr  = pc;
    assign halted    = (state == HALT);
    assign dbg_state = state;
    assign is_halt   = (instData[INST_W-1 -: 4] == HALT_OP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            instD  <= NOP_INST;
            pcD    <= '0;
            validD <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            instD  <= inst_nx;
            pcD    <= pcd_nx;
            validD <= valid_nx;
        end
    end

    // Redirect beats stall; instData is only sampled in RUN so memory X's never land in IF/ID.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        inst_nx  = instD;
        pcd_nx   = pcD;
        valid_nx = validD;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (selPC) begin
                    pc_nx    = branchTarget;
                    inst_nx  = NOP_INST;
                    valid_nx = 1'b0;
                end else if (!stopPipe) begin
                    inst_nx  = instData;
                    pcd_nx   = pc;
                    valid_nx = 1'b1;
                    if (is_halt) state_nx = HALT;
                    else         pc_nx    = pc + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            HALT: begin
                if (selPC) begin
                    pc_nx    = branchTarget;
                    inst_nx  = NOP_INST;
                    valid_nx = 1'b0;
                    state_nx = RUN;
                end else if (!stopPipe) begin
                    inst_nx  = NOP_INST;
                    valid_nx = 1'b0;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized stall/redirect traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stopPipe, selPC;
    logic [15:0] branchTarget, instAddr, instData, instD, pcD;
    logic        validD, halted;
    logic [1:0]  dbg_state;

    logic [15:0] rom [0:65535];
    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [15:0] m_pc, m_inst, m_pcd;
    logic        m_valid, m_halted, m_boot;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stopPipe(stopPipe), .selPC(selPC),
        .branchTarget(branchTarget), .instAddr(instAddr), .instData(instData),
        .instD(instD), .pcD(pcD), .validD(validD), .halted(halted),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    assign instData = rom[instAddr];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instAddr"}, instAddr, m_pc);
        check({tag, ".instD"}, instD, m_inst);
        check({tag, ".pcD"}, pcD, m_pcd);
        check({tag, ".validD"}, {15'd0, validD}, {15'd0, m_valid});
        check({tag, ".halted"}, {15'd0, halted}, {15'd0, m_halted});
    endtask

    function automatic void model_reset();
        m_pc = 16'h0000; m_inst = 16'h0000; m_pcd = 16'h0000;
        m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
    endfunction

    function automatic void model_edge();
        logic [15:0] word;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (selPC) begin
            m_pc = branchTarget; m_inst = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
        end else if (m_halted) begin
            if (!stopPipe) begin
                m_inst = 16'h0000; m_valid = 1'b0;
            end
        end else if (!stopPipe) begin
            word = rom[m_pc];
            m_inst = word; m_pcd = m_pc; m_valid = 1'b1;
            if (word[15:12] == 4'hF) m_halted = 1'b1;
            else                     m_pc = m_pc + 16'd1;
        end
    endfunction

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic s, input logic p, input logic [15:0] t);
        stopPipe = s; selPC = p; branchTarget = t;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 16'(16'h1000 + i);
        drive(1'b0, 1'b0, 16'h0000);
        rst = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: boot bubble then sequential fetch
        step("t1_boot");
        for (int i = 0; i < 5; i++) step("t1_run");
        check("t1_instD_1004", instD, 16'h1004);

        // 2: three-cycle stall at PC=5
        drive(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step("t2_stall");
        drive(1'b0, 1'b0, 16'h0000);
        step("t2_resume");
        check("t2_pcD_5", pcD, 16'h0005);

        // 3: redirect together with stall
        drive(1'b1, 1'b1, 16'h0040);
        step("t3_redir");
        drive(1'b0, 1'b0, 16'h0000);
        step("t3_target");
        check("t3_instD", instD, 16'h1040);

        // 4: HALT at address 3, first HALT edge stalled
        rom[3] = 16'hF000;
        drive(1'b0, 1'b1, 16'h0000);
        step("t4_redir0");
        drive(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) step("t4_run");
        check("t4_instD_halt", instD, 16'hF000);
        drive(1'b1, 1'b0, 16'h0000);
        step("t4_halt_stall");
        drive(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step("t4_halted");
        check("t4_addr_frozen", instAddr, 16'h0003);
        drive(1'b0, 1'b1, 16'h0000);
        step("t4_exit");
        drive(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) step("t4_refetch");
        rom[3] = 16'h1003;

        // 5: PC wrap from FFFF
        drive(1'b0, 1'b1, 16'hFFFF);
        step("t5_redir");
        drive(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) step("t5_wrap");

        // 6: asynchronous reset mid-cycle
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("t6_async");
        @(posedge clk); #1;
        check_all("t6_held");
        rst = 1'b1;
        step("t6_boot");
        step("t6_run");

        // random traffic over random memory contents
        for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  16'($urandom_range(0, 255)));
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
